// File: rtl/fixed_divider_seq_if.sv
// Purpose : start/done request bus between the calculator controller and the Q16.16 divider.
// Latency : n/a (signal bundle only).
// Backpressure: none; the requester must wait for busy=0 and hold start until it is accepted.
//
// Signals:
//   start        requester -> divider  request strobe
//   a, b         requester -> divider  dividend / divisor, sampled when start is accepted
//   busy         divider -> requester  division in progress
//   done         divider -> requester  one-cycle completion pulse
//   result       divider -> requester  quotient, held until the next accepted request
//   overflow     divider -> requester  quotient magnitude did not fit the signed range
//   div_by_zero  divider -> requester  divisor was zero
interface fixed_divider_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, result, overflow, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, overflow, div_by_zero
  );
endinterface

// File: rtl/fixed_divider_seq.sv
// Purpose : sequential signed Q16.16 divider, restoring radix-2, one quotient bit per clock.
// Latency : done pulses in the cycle after accept+48 edges (cycle after accept when b==0).
// Backpressure: start is only taken in IDLE; requests during CALC/DONE are dropped, hold start.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; aborts any division in flight
//   bus    fixed_divider_seq_if.slave (start/a/b in; busy/done/result/overflow/div_by_zero out)
//
// Build option: FIXED_DIV_SATURATE_EN
//   defined   -> an overflowing quotient saturates to 0x7FFFFFFF / 0x80000000
//   undefined -> an overflowing quotient wraps to its low WIDTH bits
//   overflow is reported in both builds; divide-by-zero handling does not change.
module fixed_divider_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fixed_divider_seq_if.slave  bus
);

  // One quotient bit per iteration; the dividend is |a| scaled by 2^FRAC.
  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N);

  // Largest magnitudes that still fit the signed result for each sign.
  localparam logic [N-1:0] POS_LIM = {{(N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [N-1:0] NEG_LIM = POS_LIM + N'(1);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Datapath state
  logic             sign_q;     // sign of the final quotient
  logic [WIDTH-1:0] bmag_q;     // |b|
  logic [N-1:0]     dvd_q;      // dividend bits shift out of the top, quotient bits shift in below
  logic [WIDTH-1:0] rem_q;      // partial remainder, always < |b| between iterations
  logic [CW-1:0]    cnt_q;      // iteration index 0..N-1
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             dz_q;

  // Control strobes from the FSM
  logic accept;
  logic last_iter;

  // ---------------------------------------------------------------------------
  // Operand conditioning at accept
  // ---------------------------------------------------------------------------
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] dz_result;

  // Unsigned WIDTH-bit magnitudes are enough: the most negative operand maps to
  // 2^(WIDTH-1), which is still representable without a sign bit.
  always_comb begin
    b_zero    = (bus.b == '0);
    a_mag     = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
    b_mag     = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
    dz_result = bus.a[WIDTH-1] ? MIN_NEG : MAX_POS;
  end

  // ---------------------------------------------------------------------------
  // One restoring-division iteration
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   rem_sh;     // one extra bit: shifted remainder can reach 2*|b|-1
  logic             q_bit;
  logic [WIDTH-1:0] rem_d;
  logic [N-1:0]     dvd_d;

  always_comb begin
    rem_sh = {rem_q, dvd_q[N-1]};
    q_bit  = (rem_sh >= {1'b0, bmag_q});
    // When subtracting, the difference is < |b| so WIDTH-bit wraparound is exact.
    rem_d  = q_bit ? (rem_sh[WIDTH-1:0] - bmag_q) : rem_sh[WIDTH-1:0];
    dvd_d  = {dvd_q[N-2:0], q_bit};
  end

  // ---------------------------------------------------------------------------
  // Result formation on the final iteration
  // ---------------------------------------------------------------------------
  logic [N-1:0]     q_fin;      // full magnitude quotient including this cycle's bit
  logic [WIDTH-1:0] q_low;
  logic [WIDTH-1:0] q_signed;
  logic             q_ovf;
  logic [WIDTH-1:0] q_result;

  always_comb begin
    q_fin    = dvd_d;
    q_low    = q_fin[WIDTH-1:0];
    // Negating a zero magnitude yields zero, so no negative zero can appear.
    q_signed = sign_q ? (~q_low + 1'b1) : q_low;
    q_ovf    = (q_fin > (sign_q ? NEG_LIM : POS_LIM));
    q_result = q_signed;
    if (q_ovf) begin
`ifdef FIXED_DIV_SATURATE_EN
      q_result = sign_q ? MIN_NEG : MAX_POS;
`else
      q_result = q_signed;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_iter = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          // A zero divisor is resolved immediately, skipping the iterations.
          state_d = b_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == CW'(N-1)) begin
          last_iter = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      bmag_q   <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else if (accept) begin
      sign_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      bmag_q <= b_mag;
      dvd_q  <= {a_mag, {FRAC{1'b0}}};
      rem_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      dz_q   <= 1'b0;
      if (b_zero) begin
        dz_q     <= 1'b1;
        result_q <= dz_result;
      end
    end else if (state_q == CALC) begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q + 1'b1;
      if (last_iter) begin
        result_q <= q_result;
        ovf_q    <= q_ovf;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy        = (state_q == CALC);
  assign bus.done        = (state_q == DONE);
  assign bus.result      = result_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_fixed_divider_seq.sv
// Purpose : self-checking bench for fixed_divider_seq (directed table, corner sequences, random vs model).
// Latency : expects done in the cycle after accept+48 (after accept for b==0).
// Backpressure: exercises start during busy, start in the DONE cycle, and reset mid-division.
module tb_fixed_divider_seq;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;
  localparam int LAT_N = WIDTH + FRAC + 1;  // sample cycles from accept to done

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  fixed_divider_seq_if #(.WIDTH(WIDTH)) dif ();

  fixed_divider_seq #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division of |a|*2^16 by |b|, then sign and range rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o, output logic d);
    longint sa, sb, sv;
    longint unsigned am, bm, q;
    bit s;
    o = 1'b0;
    d = 1'b0;
    if (b == 32'h0) begin
      d = 1'b1;
      r = a[31] ? 32'h80000000 : 32'h7FFFFFFF;
      return;
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    am = (sa < 0) ? longint'(-sa) : sa;
    bm = (sb < 0) ? longint'(-sb) : sb;
    q  = (am * 65536) / bm;
    s  = a[31] ^ b[31];
    o  = s ? (q > 64'h80000000) : (q > 64'h7FFFFFFF);
    sv = s ? -longint'(q) : longint'(q);
    r  = sv[31:0];
`ifdef FIXED_DIV_SATURATE_EN
    if (o) r = s ? 32'h80000000 : 32'h7FFFFFFF;
`endif
  endfunction

  // Issue one request and wait (bounded) for done; lat counts negedges after the accept edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic ovf, output logic dz,
                        output int lat, output logic busy1, output logic busyd);
    @(negedge clk);
    dif.a     = a;
    dif.b     = b;
    dif.start = 1'b1;
    lat   = -1;
    res   = 32'h0;
    ovf   = 1'b0;
    dz    = 1'b0;
    busy1 = 1'b0;
    busyd = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        dif.start = 1'b0;
        busy1 = dif.busy;
      end
      if (dif.done) begin
        lat   = c;
        res   = dif.result;
        ovf   = dif.overflow;
        dz    = dif.div_by_zero;
        busyd = dif.busy;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  logic [31:0] r_res;
  logic        r_ovf, r_dz, r_b1, r_bd;
  int          r_lat;

  initial begin
    logic [31:0] e_res;
    logic        e_ovf, e_dz;
    logic [31:0] ra, rb;
    int          ndone, first_done;
    logic [31:0] first_res;

    vecs[0] = '{"div6by2",    32'h00060000, 32'h00020000, 32'h00030000, 1'b0, 1'b0, LAT_N};
    vecs[1] = '{"div1by3",    32'h00010000, 32'h00030000, 32'h00005555, 1'b0, 1'b0, LAT_N};
    vecs[2] = '{"negdiv",     32'hFFFA0000, 32'h00040000, 32'hFFFE8000, 1'b0, 1'b0, LAT_N};
    vecs[3] = '{"negzero",    32'h00000001, 32'hFFFE0000, 32'h00000000, 1'b0, 1'b0, LAT_N};
    vecs[4] = '{"dz_pos",     32'h00050000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1};
    vecs[5] = '{"dz_neg",     32'hFFFF0000, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 1};
`ifdef FIXED_DIV_SATURATE_EN
    vecs[6] = '{"ovf_big",    32'h7FFF0000, 32'h00000100, 32'h7FFFFFFF, 1'b1, 1'b0, LAT_N};
    vecs[7] = '{"ovf_minm1",  32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF, 1'b1, 1'b0, LAT_N};
`else
    vecs[6] = '{"ovf_big",    32'h7FFF0000, 32'h00000100, 32'hFF000000, 1'b1, 1'b0, LAT_N};
    vecs[7] = '{"ovf_minm1",  32'h80000000, 32'hFFFF0000, 32'h80000000, 1'b1, 1'b0, LAT_N};
`endif
    vecs[8] = '{"min_by1",    32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0, LAT_N};
    vecs[9] = '{"dz_zero",    32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1};

    // Reset state
    rst_n     = 1'b0;
    dif.start = 1'b0;
    dif.a     = 32'h0;
    dif.b     = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   {31'h0, dif.busy},        32'h0);
    chk("rst_done",   {31'h0, dif.done},        32'h0);
    chk("rst_result", dif.result,               32'h0);
    chk("rst_ovf",    {31'h0, dif.overflow},    32'h0);
    chk("rst_dz",     {31'h0, dif.div_by_zero}, 32'h0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, r_res, r_ovf, r_dz, r_lat, r_b1, r_bd);
      chk({vecs[i].name, "_result"}, r_res, vecs[i].res);
      chk({vecs[i].name, "_ovf"},    {31'h0, r_ovf}, {31'h0, vecs[i].ovf});
      chk({vecs[i].name, "_dz"},     {31'h0, r_dz},  {31'h0, vecs[i].dz});
      chk({vecs[i].name, "_lat"},    32'(r_lat),     32'(vecs[i].lat));
      chk({vecs[i].name, "_busy1"},  {31'h0, r_b1},  {31'h0, (vecs[i].lat != 1)});
      chk({vecs[i].name, "_busyd"},  {31'h0, r_bd},  32'h0);
    end

    // start presented in the DONE cycle must be dropped (b=0 would finish at once if taken)
    run_op(32'h00060000, 32'h00020000, r_res, r_ovf, r_dz, r_lat, r_b1, r_bd);
    dif.a     = 32'h00010000;
    dif.b     = 32'h0;
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (dif.done || dif.busy) ndone++;
      @(negedge clk);
    end
    chk("start_in_done_ignored", 32'(ndone), 32'h0);
    chk("start_in_done_result",  dif.result, 32'h00030000);

    // start pulsed while busy: exactly one done with the original operands
    @(negedge clk);
    dif.a     = 32'h00060000;
    dif.b     = 32'h00020000;
    dif.start = 1'b1;
    ndone      = 0;
    first_done = -1;
    first_res  = 32'h0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (c == 1) dif.start = 1'b0;
      if (c == 5) begin
        dif.a     = 32'h00010000;
        dif.b     = 32'h0;
        dif.start = 1'b1;
      end
      if (c == 9) dif.start = 1'b0;
      if (dif.done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = c;
          first_res  = dif.result;
        end
      end
    end
    chk("busy_start_ndone",  32'(ndone),      32'h1);
    chk("busy_start_lat",    32'(first_done), 32'(LAT_N));
    chk("busy_start_result", first_res,       32'h00030000);

    // Reset asserted at CALC edge 10 aborts the division
    @(negedge clk);
    dif.a     = 32'h7FFF0000;
    dif.b     = 32'h00000100;
    dif.start = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 1) dif.start = 1'b0;
      if (c == 10) rst_n = 1'b0;
      if (c == 11) begin
        chk("abort_busy",   {31'h0, dif.busy},        32'h0);
        chk("abort_done",   {31'h0, dif.done},        32'h0);
        chk("abort_result", dif.result,               32'h0);
        chk("abort_ovf",    {31'h0, dif.overflow},    32'h0);
        chk("abort_dz",     {31'h0, dif.div_by_zero}, 32'h0);
        rst_n = 1'b1;
      end
      if (dif.done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'h0);
    run_op(32'h00010000, 32'h00030000, r_res, r_ovf, r_dz, r_lat, r_b1, r_bd);
    chk("after_abort_result", r_res,       32'h00005555);
    chk("after_abort_lat",    32'(r_lat),  32'(LAT_N));

    // Random operands against the arithmetic model
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      if (sel == 0) begin
        rb = 32'h0;
      end else if (sel <= 3) begin
        rb = $urandom_range(1, 32'h0000FFFF);
        if ($urandom_range(0, 1) == 1) rb = ~rb + 32'h1;
      end else begin
        rb = $urandom;
      end
      if (sel == 9) ra = ra >> $urandom_range(0, 31);
      model(ra, rb, e_res, e_ovf, e_dz);
      run_op(ra, rb, r_res, r_ovf, r_dz, r_lat, r_b1, r_bd);
      chk($sformatf("rnd%0d_result_a%h_b%h", i, ra, rb), r_res, e_res);
      chk($sformatf("rnd%0d_ovf", i), {31'h0, r_ovf}, {31'h0, e_ovf});
      chk($sformatf("rnd%0d_dz", i),  {31'h0, r_dz},  {31'h0, e_dz});
      chk($sformatf("rnd%0d_lat", i), 32'(r_lat), (rb == 32'h0) ? 32'h1 : 32'(LAT_N));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
